// File: rtl/regfile_mp_pkg.sv
// Shared defaults for the multi-port register file and its busy scoreboard.
package regfile_mp_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int NRD_DEF    = 2;
  localparam int ZERO_REG   = 0;

endpackage

// File: rtl/regfile_sb.sv
// Busy scoreboard: one pending-producer bit per register plus a registered population count.
module regfile_sb
  import regfile_mp_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                  Clock,
  input  logic                  Reset,
  input  logic [1:0]            We,
  input  logic [2*ADDR_W-1:0]   Wn,
  input  logic                  Alloc,
  input  logic [ADDR_W-1:0]     AllocN,
  output logic [2**ADDR_W-1:0]  busy,
  output logic [ADDR_W:0]       BusyCnt
);

  localparam int                DEPTH = 2**ADDR_W;
  localparam int                CNT_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] ZR    = ADDR_W'(ZERO_REG);

  logic [ADDR_W-1:0] wn0, wn1;
  logic              clr0, clr1, set, inc, dec0, dec1;
  logic [DEPTH-1:0]  busy_nxt;

  assign wn0  = Wn[0 +: ADDR_W];
  assign wn1  = Wn[ADDR_W +: ADDR_W];
  assign clr0 = We[0] && (wn0 != ZR);
  assign clr1 = We[1] && (wn1 != ZR);
  assign set  = Alloc && (AllocN != ZR);

  // Count changes only for bits that actually flip; a re-alloc in the same
  // cycle as a write keeps the register busy, and a shared target clears once.
  assign inc  = set && !busy[AllocN];
  assign dec0 = clr0 && busy[wn0] && !(set && (AllocN == wn0));
  assign dec1 = clr1 && busy[wn1] && !(set && (AllocN == wn1)) && !(clr0 && (wn0 == wn1));

  always_comb begin
    busy_nxt = busy;
    if (clr0) busy_nxt[wn0] = 1'b0;
    if (clr1) busy_nxt[wn1] = 1'b0;
    if (set)  busy_nxt[AllocN] = 1'b1;
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      busy    <= '0;
      BusyCnt <= '0;
    end else begin
      busy    <= busy_nxt;
      BusyCnt <= BusyCnt + CNT_W'(inc) - CNT_W'(dec0) - CNT_W'(dec1);
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// Two-write, NRD-read register file with write-through bypass and busy scoreboard.
module regfile_mp
  import regfile_mp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int NRD    = NRD_DEF
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [NRD*ADDR_W-1:0]    Rn,
  output logic [NRD*DATA_W-1:0]    Out,
  output logic [NRD-1:0]           RdBusy,
  input  logic [1:0]               We,
  input  logic [2*ADDR_W-1:0]      Wn,
  input  logic [2*DATA_W-1:0]      Wd,
  input  logic                     Alloc,
  input  logic [ADDR_W-1:0]        AllocN,
  output logic [ADDR_W:0]          BusyCnt
);

  localparam int                DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W-1:0] ZR    = ADDR_W'(ZERO_REG);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [ADDR_W-1:0] wn0, wn1;
  logic [DATA_W-1:0] wd0, wd1;
  logic              wr0, wr1;

  assign wn0 = Wn[0 +: ADDR_W];
  assign wn1 = Wn[ADDR_W +: ADDR_W];
  assign wd0 = Wd[0 +: DATA_W];
  assign wd1 = Wd[DATA_W +: DATA_W];
  assign wr0 = We[0] && (wn0 != ZR);
  assign wr1 = We[1] && (wn1 != ZR);

  // Port 1 is written last so it wins a same-address collision.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr0) mem[wn0] <= wd0;
      if (wr1) mem[wn1] <= wd1;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              hit0, hit1;

    assign ra   = Rn[k*ADDR_W +: ADDR_W];
    assign hit0 = wr0 && (wn0 == ra);
    assign hit1 = wr1 && (wn1 == ra);

    // Bypass is not gated by Reset so in-flight write data stays visible.
    assign Out[k*DATA_W +: DATA_W] = hit1 ? wd1 : (hit0 ? wd0 : mem[ra]);
    assign RdBusy[k]               = busy[ra] && !(hit0 || hit1);
  end

  regfile_sb #(
    .ADDR_W (ADDR_W)
  ) u_sb (
    .Clock   (Clock),
    .Reset   (Reset),
    .We      (We),
    .Wn      (Wn),
    .Alloc   (Alloc),
    .AllocN  (AllocN),
    .busy    (busy),
    .BusyCnt (BusyCnt)
  );

endmodule

// File: tb/tb_regfile_mp.sv
// Table-driven bench for regfile_mp: expected values queued at drive, compared before the next edge.
module tb_regfile_mp;

  logic        Clock;
  logic        Reset;
  logic [9:0]  Rn;
  logic [63:0] Out;
  logic [1:0]  RdBusy;
  logic [1:0]  We;
  logic [9:0]  Wn;
  logic [63:0] Wd;
  logic        Alloc;
  logic [4:0]  AllocN;
  logic [5:0]  BusyCnt;

  int errors = 0;
  int checks = 0;

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NRD(2)) dut (
    .Clock   (Clock),
    .Reset   (Reset),
    .Rn      (Rn),
    .Out     (Out),
    .RdBusy  (RdBusy),
    .We      (We),
    .Wn      (Wn),
    .Wd      (Wd),
    .Alloc   (Alloc),
    .AllocN  (AllocN),
    .BusyCnt (BusyCnt)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  typedef struct {
    string       tag;
    logic [1:0]  we;
    logic [4:0]  wn0;
    logic [31:0] wd0;
    logic [4:0]  wn1;
    logic [31:0] wd1;
    logic        alloc;
    logic [4:0]  allocn;
    logic [4:0]  rn0;
    logic [4:0]  rn1;
    logic [31:0] eo0;
    logic [31:0] eo1;
    logic [1:0]  erb;
    logic [5:0]  ecnt;
  } vec_t;

  typedef struct {
    string       tag;
    logic [31:0] eo0;
    logic [31:0] eo1;
    logic [1:0]  erb;
    logic [5:0]  ecnt;
  } exp_t;

  exp_t exp_q[$];
  vec_t tbl[20];

  function automatic vec_t mkv(string tag, logic [1:0] we, logic [4:0] wn0, logic [31:0] wd0,
                               logic [4:0] wn1, logic [31:0] wd1, logic alloc, logic [4:0] allocn,
                               logic [4:0] rn0, logic [4:0] rn1, logic [31:0] eo0, logic [31:0] eo1,
                               logic [1:0] erb, logic [5:0] ecnt);
    vec_t v;
    v.tag = tag; v.we = we; v.wn0 = wn0; v.wd0 = wd0; v.wn1 = wn1; v.wd1 = wd1;
    v.alloc = alloc; v.allocn = allocn; v.rn0 = rn0; v.rn1 = rn1;
    v.eo0 = eo0; v.eo1 = eo1; v.erb = erb; v.ecnt = ecnt;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    We     = v.we;
    Wn     = {v.wn1, v.wn0};
    Wd     = {v.wd1, v.wd0};
    Alloc  = v.alloc;
    AllocN = v.allocn;
    Rn     = {v.rn1, v.rn0};
    e.tag = v.tag; e.eo0 = v.eo0; e.eo1 = v.eo1; e.erb = v.erb; e.ecnt = v.ecnt;
    exp_q.push_back(e);
  endtask

  task automatic sample();
    exp_t e;
    #1;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL queue_empty: got 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      chk({e.tag, ".out0"},   64'(Out[31:0]),  64'(e.eo0));
      chk({e.tag, ".out1"},   64'(Out[63:32]), 64'(e.eo1));
      chk({e.tag, ".rdbusy"}, 64'(RdBusy),     64'(e.erb));
      chk({e.tag, ".cnt"},    64'(BusyCnt),    64'(e.ecnt));
    end
  endtask

  task automatic check_now(input vec_t v);
    apply(v);
    sample();
  endtask

  task automatic step(input vec_t v);
    check_now(v);
    @(posedge Clock);
    @(negedge Clock);
  endtask

  initial begin
    // tag, we, wn0, wd0, wn1, wd1, alloc, allocn, rn0, rn1, out0, out1, rdbusy, cnt
    tbl[0]  = mkv("rst_idle",   2'b00, 0, 0,            0, 0,     0, 0, 0, 0, 0,            0,            2'b00, 0);
    tbl[1]  = mkv("wr_r5",      2'b01, 5, 32'h12345678, 0, 0,     0, 0, 5, 1, 32'h12345678, 0,            2'b00, 0);
    tbl[2]  = mkv("rd_r5",      2'b00, 0, 0,            0, 0,     0, 0, 5, 5, 32'h12345678, 32'h12345678, 2'b00, 0);
    tbl[3]  = mkv("byp_r7",     2'b01, 7, 32'hAAAA0000, 0, 0,     0, 0, 7, 5, 32'hAAAA0000, 32'h12345678, 2'b00, 0);
    tbl[4]  = mkv("dual_r3",    2'b11, 3, 32'h1,        3, 32'h2, 0, 0, 3, 7, 32'h2,        32'hAAAA0000, 2'b00, 0);
    tbl[5]  = mkv("wr_r0",      2'b01, 0, 32'hFFFFFFFF, 0, 0,     0, 0, 3, 0, 32'h2,        0,            2'b00, 0);
    tbl[6]  = mkv("rd_r0",      2'b00, 0, 0,            0, 0,     0, 0, 0, 3, 0,            32'h2,        2'b00, 0);
    tbl[7]  = mkv("alloc_r9",   2'b00, 0, 0,            0, 0,     1, 9, 9, 9, 0,            0,            2'b00, 0);
    tbl[8]  = mkv("busy_r9",    2'b00, 0, 0,            0, 0,     0, 0, 9, 0, 0,            0,            2'b01, 1);
    tbl[9]  = mkv("wralloc_r9", 2'b01, 9, 32'h99,       0, 0,     1, 9, 9, 9, 32'h99,       32'h99,       2'b00, 1);
    tbl[10] = mkv("still_busy", 2'b00, 0, 0,            0, 0,     0, 0, 9, 0, 32'h99,       0,            2'b01, 1);
    tbl[11] = mkv("wr1_r9",     2'b10, 0, 0,            9, 32'h55,0, 0, 9, 3, 32'h55,       32'h2,        2'b00, 1);
    tbl[12] = mkv("clr_r9",     2'b00, 0, 0,            0, 0,     0, 0, 9, 9, 32'h55,       32'h55,       2'b00, 0);
    tbl[13] = mkv("alloc_r4",   2'b00, 0, 0,            0, 0,     1, 4, 4, 0, 0,            0,            2'b00, 0);
    tbl[14] = mkv("alloc_r0",   2'b00, 0, 0,            0, 0,     1, 0, 4, 0, 0,            0,            2'b01, 1);
    tbl[15] = mkv("dualclr_r4", 2'b11, 4, 32'h10,       4, 32'h20,0, 0, 4, 4, 32'h20,       32'h20,       2'b00, 1);
    tbl[16] = mkv("r4_clear",   2'b00, 0, 0,            0, 0,     0, 0, 4, 0, 32'h20,       0,            2'b00, 0);
    tbl[17] = mkv("alloc_r6",   2'b00, 0, 0,            0, 0,     1, 6, 6, 0, 0,            0,            2'b00, 0);
    tbl[18] = mkv("realloc_r6", 2'b00, 0, 0,            0, 0,     1, 6, 6, 0, 0,            0,            2'b01, 1);
    tbl[19] = mkv("r6_once",    2'b00, 0, 0,            0, 0,     0, 0, 6, 0, 0,            0,            2'b01, 1);

    Reset = 1'b1;
    We = '0; Wn = '0; Wd = '0; Alloc = 1'b0; AllocN = '0; Rn = '0;
    repeat (2) @(negedge Clock);
    Reset = 1'b0;

    foreach (tbl[i]) step(tbl[i]);

    // Fill r1..r31; r6 is already busy so it adds nothing when re-allocated.
    for (int i = 1; i <= 31; i++) begin
      step(mkv("fill", 2'b00, 0, 0, 0, 0, 1, 5'(i), 0, 0, 0, 0, 2'b00,
               6'((i - 1) + ((i <= 6) ? 1 : 0))));
    end
    step(mkv("full",      2'b00, 0, 0,          0, 0,          0, 0, 31, 1, 0,          0,          2'b11, 31));
    step(mkv("clr_r1_r2", 2'b11, 1, 32'h111,    2, 32'h222,    0, 0, 1,  2, 32'h111,    32'h222,    2'b00, 31));
    step(mkv("after_clr", 2'b00, 0, 0,          0, 0,          0, 0, 1,  2, 32'h111,    32'h222,    2'b00, 29));

    // Reset between edges with data and busy bits live.
    check_now(mkv("pre_rst",  2'b00, 0, 0, 0, 0, 0, 0, 5, 3, 32'h12345678, 32'h2, 2'b11, 29));
    Reset = 1'b1;
    check_now(mkv("in_rst",   2'b00, 0, 0, 0, 0, 0, 0, 5, 3, 0, 0, 2'b00, 0));
    check_now(mkv("rst_byp",  2'b01, 5, 32'hDEAD, 0, 0, 1, 8, 5, 8, 32'hDEAD, 0, 2'b00, 0));
    @(posedge Clock);
    @(negedge Clock);
    Reset = 1'b0;
    check_now(mkv("post_rst", 2'b00, 0, 0, 0, 0, 0, 0, 5, 8, 0, 0, 2'b00, 0));
    @(posedge Clock);
    @(negedge Clock);
    step(mkv("pu_wr",    2'b01, 5, 32'h77, 0, 0, 1, 8, 5, 8, 32'h77, 0, 2'b00, 0));
    step(mkv("pu_rd",    2'b00, 0, 0,      0, 0, 0, 0, 5, 8, 32'h77, 0, 2'b10, 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register data width.
REQ-002 SHALL have parameter ADDR_W, default 5, address width; depth = 2**ADDR_W.
REQ-003 SHALL have parameter NRD, default 2, number of read ports (1..4).
REQ-004 SHALL use one clock and an asynchronous, active-high reset.
REQ-005 Clock  in  1  rising-edge clock.
REQ-006 Reset  in  1  asynchronous, active-high reset.
REQ-007 Rn  in  NRD*ADDR_W  read addresses; port k occupies bits [k*ADDR_W +: ADDR_W].
REQ-008 Out  out  NRD*DATA_W  read data; port k occupies bits [k*DATA_W +: DATA_W].
REQ-009 RdBusy  out  NRD  scoreboard busy flag for each read address.
REQ-010 We  in  2  write enables for write ports 0 and 1.
REQ-011 Wn  in  2*ADDR_W  write addresses; port j occupies bits [j*ADDR_W +: ADDR_W].
REQ-012 Wd  in  2*DATA_W  write data; port j occupies bits [j*DATA_W +: DATA_W].
REQ-013 Alloc  in  1  marks register AllocN busy (pending producer).
REQ-014 AllocN  in  ADDR_W  address to allocate.
REQ-015 BusyCnt  out  ADDR_W+1  number of registers currently busy.

Function
REQ-016 Register 0 SHALL always read 0 and is never busy; writes and allocs to address 0 SHALL be ignored.
REQ-017 Writes SHALL commit on the rising edge of Clock when We[j]=1 and Wn[j]!=0.
REQ-018 When both write ports target the same nonzero address in one cycle, port 1 SHALL win for both storage and bypass.
REQ-019 Reads SHALL be combinational; when a same-cycle write targets Rn[k]!=0, Out[k] SHALL equal that write data (bypass), with port 1 taking priority; otherwise Out[k] SHALL equal the stored value.
REQ-020 The busy bit of register r SHALL be set on the clock edge when Alloc=1 and AllocN=r!=0.
REQ-021 The busy bit SHALL be cleared on the clock edge when either write port commits to r.
REQ-022 A simultaneous alloc and write to the same r SHALL leave r busy (the new producer wins).
REQ-023 RdBusy[k] SHALL equal busy[Rn[k]] AND NOT (same-cycle write to Rn[k]); it SHALL be 0 for address 0.
REQ-024 BusyCnt SHALL be a registered count equal to the population of busy bits after each edge; it SHALL be updated incrementally (+1 for a set, -1 per distinct cleared busy register, no change for re-allocating an already-busy register) and SHALL never wrap (maximum 2**ADDR_W-1).
REQ-025 Read latency SHALL be 0 cycles; write-to-stored latency SHALL be 1 edge; alloc-to-RdBusy latency SHALL be 1 edge.

Reset
REQ-026 Reset=1 SHALL immediately clear all registers to 0, all busy bits to 0 and BusyCnt to 0, independent of Clock.
REQ-027 Writes and allocs presented while Reset=1 SHALL be discarded; bypass data SHALL still appear on Out combinationally.
REQ-028 Reset asserted mid-operation SHALL leave no partial state; the first edge after release SHALL behave as from power-up.

Structure
REQ-029 A shared package SHALL hold the default DATA_W, ADDR_W and NRD constants and the ZERO_REG address constant.
REQ-030 The scoreboard (busy bits and BusyCnt) SHALL be a sub-module named regfile_sb; the storage, bypass and read muxes stay in regfile_mp.

Verification
REQ-031 Write 0x12345678 to r5 via port 0, then read r5 on every port on the next cycle -> 0x12345678 on every port.
REQ-032 Same-cycle write of 0xAAAA0000 to r7 while Rn[0]=7 -> Out[0]=0xAAAA0000 in that cycle, before the edge.
REQ-033 Both ports write r3 (port 0 0x1, port 1 0x2) -> bypass and stored value are both 0x2; write 0xFFFFFFFF to r0 -> r0 reads 0.
REQ-034 Alloc r9 -> RdBusy=1 and BusyCnt=1; then write r9 while allocating r9 -> still busy, BusyCnt=1; then write r9 alone -> RdBusy=0, BusyCnt=0.
REQ-035 Allocate r1..r31 on successive cycles -> BusyCnt=31; then two ports clear r1 and r2 in one cycle -> BusyCnt=29.
REQ-036 Assert Reset between clock edges with data and busy bits set -> all Out=0, RdBusy=0, BusyCnt=0 immediately; writes presented during reset are not stored.
